// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the ProgCtr run-control sequencer.
// Also holds the branch-target resolution helper used by the LUT.
package pc_seq_pkg;

  localparam int PC_W      = 9;
  localparam int IDX_W     = 5;
  localparam int CNT_W     = 16;
  localparam int LUT_DEPTH = 2 ** IDX_W;

  localparam logic [PC_W-1:0]  PC_LAST = 9'd511;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic            rel;
    logic [PC_W-1:0] val;
  } lut_entry_t;

  // A relative entry is a two's-complement offset of PC width, so a plain
  // truncating add gives (PC + sign-extended value) mod 2**PC_W.
  function automatic logic [PC_W-1:0] resolve_target(input lut_entry_t entry,
                                                     input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] result;
    if (entry.rel) begin
      result = pc + entry.val;
    end else begin
      result = entry.val;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_lut.sv
// Writable 32-entry branch-target table with combinational read and
// absolute/relative target resolution against the current PC.
module branch_lut
  import pc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  lut_entry_t       wdata,
  input  logic [IDX_W-1:0] ridx,
  input  logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  target
);

  lut_entry_t mem_r [LUT_DEPTH];
  lut_entry_t rd_entry_s;

  // Table storage; a same-index read in the write cycle still sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read and target resolution.
  always_comb begin
    rd_entry_s = mem_r[ridx];
    target     = resolve_target(rd_entry_s, pc);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Run-control FSM, branch priority mux and executed-cycle counter that
// drive ProgCtr's Start/Branch/Target inputs.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Go,
  input  logic             HaltReq,
  input  logic             Stall,
  input  logic             BrReq,
  input  logic             BrCond,
  input  logic [IDX_W-1:0] BrIdx,
  input  logic [PC_W-1:0]  PC,
  input  logic             LutWe,
  input  logic [IDX_W-1:0] LutWaddr,
  input  logic [PC_W:0]    LutWdata,
  output logic             StartPC,
  output logic             Branch,
  output logic [PC_W-1:0]  Target,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  seq_state_t       state_r;
  seq_state_t       next_s;
  logic             branch_s;
  logic [PC_W-1:0]  target_s;
  logic [PC_W-1:0]  lut_target_s;
  logic             taken_s;
  logic             start_r;
  logic             running_r;
  logic             done_r;
  logic [CNT_W-1:0] cnt_r;

  branch_lut u_lut (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .we     (LutWe),
    .waddr  (LutWaddr),
    .wdata  (lut_entry_t'(LutWdata)),
    .ridx   (BrIdx),
    .pc     (PC),
    .target (lut_target_s)
  );

  assign taken_s = BrReq & BrCond;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and Mealy branch outputs; HaltReq > Stall > taken branch > none.
  always_comb begin
    next_s   = state_r;
    branch_s = 1'b0;
    target_s = '0;
    case (state_r)
      IDLE: begin
        if (Go) begin
          next_s = INIT;
        end else begin
          next_s = IDLE;
        end
      end
      INIT: begin
        next_s = RUN;
      end
      RUN: begin
        if (HaltReq) begin
          next_s = HALT;
        end else if (Stall) begin
          // Reloading the current PC is how ProgCtr is told to hold.
          branch_s = 1'b1;
          target_s = PC;
        end else if (taken_s) begin
          branch_s = 1'b1;
          target_s = lut_target_s;
        end else if (PC == PC_LAST) begin
          next_s = HALT;
        end else begin
          next_s = RUN;
        end
      end
      HALT: begin
        if (Go) begin
          next_s = INIT;
        end else begin
          next_s = HALT;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // Registered status outputs, aligned with the state they describe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      start_r   <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      start_r   <= (next_s == INIT);
      running_r <= (next_s == RUN);
      done_r    <= (next_s == HALT);
    end
  end

  // Cycle counter; the exit edge does not count so HALT shows the value seen at halt.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_r <= '0;
    end else if (state_r == INIT) begin
      cnt_r <= '0;
    end else if ((state_r == RUN) && (next_s == RUN) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign StartPC    = start_r;
  assign Running    = running_r;
  assign Done       = done_r;
  assign CycleCount = cnt_r;
  assign Branch     = branch_s;
  assign Target     = target_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model plus a ProgCtr model
// push expected outputs each cycle; a monitor pops and compares on the falling edge.
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Go = 1'b0, HaltReq = 1'b0, Stall = 1'b0, BrReq = 1'b0, BrCond = 1'b0;
  logic [4:0] BrIdx = 5'd0;
  logic [8:0] PC = 9'd0;
  logic       LutWe = 1'b0;
  logic [4:0] LutWaddr = 5'd0;
  logic [9:0] LutWdata = 10'd0;
  logic       StartPC, Branch, Running, Done;
  logic [8:0] Target;
  logic [15:0] CycleCount;

  pc_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Go(Go), .HaltReq(HaltReq), .Stall(Stall),
    .BrReq(BrReq), .BrCond(BrCond), .BrIdx(BrIdx), .PC(PC),
    .LutWe(LutWe), .LutWaddr(LutWaddr), .LutWdata(LutWdata),
    .StartPC(StartPC), .Branch(Branch), .Target(Target),
    .Running(Running), .Done(Done), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic        start, br, run, done;
    logic [8:0]  tgt;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 idle, 1 starting, 2 running, 3 halted.
  int m_mode = 0;
  int m_cnt  = 0;
  int m_pc   = 0;
  int m_lut[32];

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pc = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = 0;
  endtask

  task automatic step(input bit go, input bit halt, input bit stall, input bit brq,
                      input bit brc, input int idx, input bit we, input int waddr,
                      input int wdata, input string tag);
    exp_t e;
    int   nmode, ent, sval, tgt;
    @(posedge Clk); #1;
    Go = go; HaltReq = halt; Stall = stall; BrReq = brq; BrCond = brc;
    BrIdx = 5'(idx); LutWe = we; LutWaddr = 5'(waddr); LutWdata = 10'(wdata);
    PC = 9'(m_pc);
    e.tag = tag; e.start = (m_mode == 1); e.run = (m_mode == 2); e.done = (m_mode == 3);
    e.cnt = 16'(m_cnt); e.br = 1'b0; e.tgt = 9'd0;
    nmode = m_mode;
    ent  = m_lut[idx];
    sval = ent % 512;
    if (sval >= 256) sval = sval - 512;
    if (ent >= 512) tgt = ((m_pc + sval) % 512 + 512) % 512;
    else            tgt = ent % 512;
    case (m_mode)
      0, 3: if (go) nmode = 1;
      1: nmode = 2;
      2: begin
        if (halt) nmode = 3;
        else if (stall) begin e.br = 1'b1; e.tgt = 9'(m_pc); end
        else if (brq && brc) begin e.br = 1'b1; e.tgt = 9'(tgt); end
        else if (m_pc == 511) nmode = 3;
      end
      default: nmode = 0;
    endcase
    exp_q.push_back(e);
    if (we) m_lut[waddr] = wdata;
    if (e.start) m_pc = 0;
    else if (e.br) m_pc = int'(e.tgt);
    else if (m_mode == 2) m_pc = (m_pc + 1) % 512;
    if (m_mode == 1) m_cnt = 0;
    else if (m_mode == 2 && nmode == 2 && m_cnt < 65535) m_cnt = m_cnt + 1;
    m_mode = nmode;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic lut_write(input int addr, input int data);
    step(0, 0, 0, 0, 0, 0, 1, addr, data, "lut_write");
  endtask

  // Reset dropped mid-cycle while a taken branch is being presented.
  task automatic async_reset();
    exp_t e;
    @(posedge Clk); #1;
    Go = 0; HaltReq = 0; Stall = 0; BrReq = 1; BrCond = 1; BrIdx = 5'd3; PC = 9'(m_pc);
    #1;
    Reset_n = 1'b0;
    e.tag = "async_reset"; e.start = 1'b0; e.br = 1'b0; e.run = 1'b0; e.done = 1'b0;
    e.tgt = 9'd0; e.cnt = 16'd0;
    exp_q.push_back(e);
    model_reset();
    @(posedge Clk); #2;
    BrReq = 0; BrCond = 0; BrIdx = 5'd0; PC = 9'd0;
    Reset_n = 1'b1;
  endtask

  // Monitor: compare the DUT against the oldest expectation each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (StartPC !== e.start || Branch !== e.br || Target !== e.tgt ||
            Running !== e.run || Done !== e.done || CycleCount !== e.cnt) begin
          errors++;
          $display("FAIL %s: got start=%0b br=%0b tgt=%0d run=%0b done=%0b cnt=%0d, expected start=%0b br=%0b tgt=%0d run=%0b done=%0b cnt=%0d",
                   e.tag, StartPC, Branch, Target, Running, Done, CycleCount,
                   e.start, e.br, e.tgt, e.run, e.done, e.cnt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    #22 Reset_n = 1'b1;

    idle(2, "reset_state");
    lut_write(3, 100);
    lut_write(4, 10'h3FB);
    lut_write(5, 200);

    // Run A: start, not-taken branch, absolute branch, stall, Go ignored, halt at 20.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "go_idle");
    idle(3, "start_count");
    step(0, 0, 0, 1, 0, 4, 0, 0, 0, "br_not_taken");
    step(0, 0, 0, 1, 1, 3, 0, 0, 0, "br_abs_100");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "go_in_run");
    step(0, 0, 1, 1, 1, 5, 0, 0, 0, "stall_branch");
    step(0, 0, 0, 1, 1, 5, 0, 0, 0, "br_after_stall");
    for (int i = 0; i < 40 && m_cnt < 20; i++) idle(1, "count_to_20");
    step(0, 1, 0, 1, 1, 3, 0, 0, 0, "halt_at_20");
    idle(3, "halt_frozen");

    // Run B: stall with taken branch at PC 7, then same-cycle write/read of an entry.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "go_halt");
    idle(8, "restart_count");
    step(0, 0, 1, 1, 1, 3, 0, 0, 0, "stall_pc7");
    step(0, 0, 0, 1, 1, 3, 1, 3, 300, "wr_rd_same_old");
    step(0, 0, 0, 1, 1, 3, 0, 0, 0, "rd_new_entry");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, "halt_b");

    // Run C: relative branch wraps to 509, then falls off PC_LAST into HALT.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "go_c");
    idle(3, "run_c");
    step(0, 0, 0, 1, 1, 4, 0, 0, 0, "br_rel_wrap");
    idle(6, "pc_last_halt");

    // Run D: reset mid-branch clears state and the LUT.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "go_d");
    idle(3, "run_d");
    async_reset();
    idle(3, "after_reset_idle");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "go_after_reset");
    idle(2, "run_after_reset");
    step(0, 0, 0, 1, 1, 3, 0, 0, 0, "lut_cleared");

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 31)),
           int'($urandom_range(0, 1023)), "random");
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clk);
    @(negedge Clk); #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
